uart_tx_frame: RTL and testbench

//  Parametrised UART transmitter with an internal baud divider and configurable frame format.

---
 rtl/uart_tx_frame.sv | 113 +++++++++++
 tb/tb_uart_tx_frame.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmitter: one Data-bit word per start/ready handshake, LSB first, optional parity, 1-2 stop bits.
// Latency: start bit appears on out 1 clk after accept; frame lasts Divisor*(1+Data+par+Stop) clks.
// Backpressure: ready stays low for the whole frame; start while not ready is dropped, never queued.
module uart_tx_frame #(
    parameter int Divisor = 434,
    parameter int Data    = 8,
    parameter int Parity  = 0,
    parameter int Stop    = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [Data-1:0] in,
    output logic            ready,
    output logic            out
);
    localparam int CW = (Divisor > 1) ? $clog2(Divisor) : 1;
    localparam int BW = $clog2(Data + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(Divisor - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(Data - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(Stop - 1);

    if (Divisor < 2 || Data < 5 || Data > 9 || Parity < 0 || Parity > 2 ||
        (Stop != 1 && Stop != 2)) begin : g_bad_params
        $error("uart_tx_frame: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state;
    logic [CW-1:0]   baud_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [Data-1:0] shreg;
    logic [Data-1:0] word;
    logic            par_bit;

    // Parity comes from the word captured at accept, independent of the shifter.
    assign par_bit = (^word) ^ (Parity == 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            out      <= 1'b1;
            ready    <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '1;
            word     <= '1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= in;
                        word     <= in;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        out      <= 1'b0;
                        ready    <= 1'b0;
                        state    <= START;
                    end
                end
                default: begin
                    if (baud_cnt != BAUD_LAST) begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end else begin
                        baud_cnt <= '0;
                        case (state)
                            START: begin
                                out   <= shreg[0];
                                shreg <= {1'b1, shreg[Data-1:1]};
                                state <= DATA;
                            end
                            DATA: begin
                                if (bit_cnt == DATA_LAST) begin
                                    bit_cnt <= '0;
                                    if (Parity != 0) begin
                                        out   <= par_bit;
                                        state <= PARITY;
                                    end else begin
                                        out   <= 1'b1;
                                        state <= STOP;
                                    end
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                    out     <= shreg[0];
                                    shreg   <= {1'b1, shreg[Data-1:1]};
                                end
                            end
                            PARITY: begin
                                out   <= 1'b1;
                                state <= STOP;
                            end
                            STOP: begin
                                if (bit_cnt == STOP_LAST) begin
                                    bit_cnt <= '0;
                                    ready   <= 1'b1;
                                    state   <= IDLE;
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                            default: begin
                                out   <= 1'b1;
                                ready <= 1'b1;
                                state <= IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four instances (no parity, even, odd, two stop bits) at Divisor=4, Data=8.
// Line monitors decode frames and compare them against a per-instance expectation queue.
module tb_uart_tx_frame;
    localparam int NCFG = 4;
    localparam int P_PAR[NCFG]  = '{0, 2, 1, 0};
    localparam int P_STOP[NCFG] = '{1, 1, 1, 2};

    typedef struct packed {
        logic [7:0] word;
        logic       par;
    } exp_t;

    typedef struct {
        int         cfg;
        logic [7:0] word;
        logic       par;
        int         len;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [NCFG-1:0] start_v;
    logic [7:0]      in_v [NCFG];
    logic [NCFG-1:0] ready_v;
    logic [NCFG-1:0] out_v;
    logic [NCFG-1:0] mon_en;

    exp_t sb [NCFG][$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        uart_tx_frame #(
            .Divisor(4),
            .Data   (8),
            .Parity (P_PAR[g]),
            .Stop   (P_STOP[g])
        ) u_dut (
            .clk  (clk),
            .reset(reset),
            .start(start_v[g]),
            .in   (in_v[g]),
            .ready(ready_v[g]),
            .out  (out_v[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Each monitor samples on falling edges; a frame is Divisor samples per bit.
    for (genvar g = 0; g < NCFG; g++) begin : g_mon
        localparam int NB = 9 + ((P_PAR[g] != 0) ? 1 : 0) + P_STOP[g];
        initial begin
            logic        prev;
            logic        cur;
            logic        smp;
            logic        stable;
            logic [15:0] bits_s;
            logic [15:0] exp_bits;
            exp_t        e;
            prev = 1'b1;
            forever begin
                @(negedge clk);
                if (mon_en[g] && reset && prev && !out_v[g]) begin
                    stable = 1'b1;
                    bits_s = '1;
                    cur    = 1'b0;
                    for (int k = 0; k < NB * 4; k++) begin
                        if (k != 0) @(negedge clk);
                        smp = out_v[g];
                        if (k % 4 == 0) begin
                            cur           = smp;
                            bits_s[k / 4] = smp;
                        end else if (smp !== cur) begin
                            stable = 1'b0;
                        end
                    end
                    chk($sformatf("frame_expected%0d", g), 32'(sb[g].size() != 0), 32'd1);
                    if (sb[g].size() != 0) begin
                        e = sb[g].pop_front();
                        exp_bits    = '1;
                        exp_bits[0] = 1'b0;
                        for (int j = 0; j < 8; j++) exp_bits[1 + j] = e.word[j];
                        if (P_PAR[g] != 0) exp_bits[9] = e.par;
                        chk($sformatf("frame_bits%0d_%0h", g, e.word), 32'(bits_s), 32'(exp_bits));
                        chk($sformatf("bit_width%0d_%0h", g, e.word), 32'(stable), 32'd1);
                    end
                end
                prev = out_v[g];
            end
        end
    end

    task automatic wait_ready(input int i, input string nm);
        int n;
        n = 0;
        while (ready_v[i] !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_rdy"}, 32'(ready_v[i]), 32'd1);
    endtask

    // seen = falling-edge samples already taken since the accept edge.
    task automatic finish_frame(input int i, input int seen, input int len, input string nm);
        int n;
        n = seen;
        while (ready_v[i] === 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_len"}, 32'(n - 1), 32'(len));
        chk({nm, "_idle"}, 32'(out_v[i]), 32'd1);
    endtask

    task automatic send(input int i, input logic [7:0] w, input logic p, input int len,
                        input string nm);
        wait_ready(i, nm);
        sb[i].push_back('{word: w, par: p});
        start_v[i] = 1'b1;
        in_v[i]    = w;
        @(negedge clk);
        start_v[i] = 1'b0;
        in_v[i]    = ~w;
        chk({nm, "_lat"}, 32'(out_v[i]), 32'd0);
        chk({nm, "_busy"}, 32'(ready_v[i]), 32'd0);
        finish_frame(i, 1, len, nm);
    endtask

    initial begin
        vec_t vecs[10];
        logic ok;

        vecs[0] = '{cfg: 0, word: 8'h55, par: 1'b0, len: 40};
        vecs[1] = '{cfg: 1, word: 8'h03, par: 1'b0, len: 44};
        vecs[2] = '{cfg: 2, word: 8'h03, par: 1'b1, len: 44};
        vecs[3] = '{cfg: 3, word: 8'hFF, par: 1'b0, len: 44};
        vecs[4] = '{cfg: 1, word: 8'hA5, par: 1'b0, len: 44};
        vecs[5] = '{cfg: 2, word: 8'h3C, par: 1'b1, len: 44};
        vecs[6] = '{cfg: 1, word: 8'h01, par: 1'b1, len: 44};
        vecs[7] = '{cfg: 2, word: 8'h07, par: 1'b0, len: 44};
        vecs[8] = '{cfg: 3, word: 8'h00, par: 1'b0, len: 44};
        vecs[9] = '{cfg: 0, word: 8'hC3, par: 1'b0, len: 40};

        reset   = 1'b1;
        start_v = '0;
        mon_en  = '1;
        for (int i = 0; i < NCFG; i++) in_v[i] = 8'h00;
        #1 reset = 1'b0;
        #1;
        chk("reset_ready", 32'(ready_v), 32'hF);
        chk("reset_out", 32'(out_v), 32'hF);
        repeat (3) @(negedge clk);
        chk("reset_hold_ready", 32'(ready_v), 32'hF);
        chk("reset_hold_out", 32'(out_v), 32'hF);
        reset = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 10; k++)
            send(vecs[k].cfg, vecs[k].word, vecs[k].par, vecs[k].len, $sformatf("vec%0d", k));

        // start held high across two frames
        wait_ready(0, "b2b");
        sb[0].push_back('{word: 8'hA5, par: 1'b0});
        sb[0].push_back('{word: 8'h3C, par: 1'b0});
        start_v[0] = 1'b1;
        in_v[0]    = 8'hA5;
        @(negedge clk);
        in_v[0] = 8'h3C;
        finish_frame(0, 1, 40, "b2b_first");
        chk("b2b_gap_ready", 32'(ready_v[0]), 32'd1);
        @(negedge clk);
        start_v[0] = 1'b0;
        in_v[0]    = 8'h00;
        chk("b2b_restart_out", 32'(out_v[0]), 32'd0);
        chk("b2b_restart_ready", 32'(ready_v[0]), 32'd0);
        finish_frame(0, 1, 40, "b2b_second");

        // start pulse mid-frame must be ignored
        wait_ready(0, "ign");
        sb[0].push_back('{word: 8'h12, par: 1'b0});
        start_v[0] = 1'b1;
        in_v[0]    = 8'h12;
        @(negedge clk);
        start_v[0] = 1'b0;
        in_v[0]    = 8'h00;
        repeat (12) @(negedge clk);
        chk("ign_busy", 32'(ready_v[0]), 32'd0);
        start_v[0] = 1'b1;
        in_v[0]    = 8'hFF;
        @(negedge clk);
        start_v[0] = 1'b0;
        finish_frame(0, 14, 40, "ign");
        ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (out_v[0] !== 1'b1 || ready_v[0] !== 1'b1) ok = 1'b0;
        end
        chk("ign_no_second", 32'(ok), 32'd1);

        // reset during data bit 3, unmonitored partial frame
        wait_ready(0, "rst");
        mon_en[0]  = 1'b0;
        start_v[0] = 1'b1;
        in_v[0]    = 8'h00;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk("rst_pre_low", 32'(out_v[0]), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_out", 32'(out_v[0]), 32'd1);
        chk("rst_async_ready", 32'(ready_v[0]), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (out_v[0] !== 1'b1 || ready_v[0] !== 1'b1) ok = 1'b0;
        end
        chk("rst_no_resume", 32'(ok), 32'd1);
        mon_en[0] = 1'b1;
        @(negedge clk);
        send(0, 8'h81, 1'b0, 40, "rst_after");

        repeat (20) @(negedge clk);
        for (int g = 0; g < NCFG; g++)
            chk($sformatf("sb_drained%0d", g), 32'(sb[g].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end
endmodule
